// File: rtl/plane_pkg.sv
// Shared constants and FSM state type for the plane spawner slice.
package plane_pkg;

  localparam int unsigned SCREEN_W  = 160;
  localparam int unsigned SCREEN_H  = 120;
  localparam int unsigned SPAWN_X   = SCREEN_W - 1;
  localparam logic [6:0]  LFSR_SEED = 7'h5A;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    SPAWN,
    EMIT
  } state_t;

endpackage

// File: rtl/lane_lfsr.sv
// 7-bit LFSR (x^7+x^6+1) folded into a spawn lane that always lies on screen.
module lane_lfsr
  import plane_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  output logic [6:0] lane
);

  logic [6:0] lfsr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= LFSR_SEED;
    end else if (enable) begin
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
  end

  // Values 120..127 fold down by 64 so y never exceeds the last screen row.
  always_comb begin
    lane = (lfsr >= 7'(SCREEN_H)) ? (lfsr - 7'd64) : lfsr;
  end

endmodule

// File: rtl/plane_spawner.sv
// Plane pool: per-tick move/retire sweep, single spawn, then valid/ready stream of live planes.
module plane_spawner
  import plane_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 10,
  parameter int unsigned X_W       = 8,
  parameter int unsigned Y_W       = 7
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           enable,
  input  logic           tick,
  input  logic [3:0]     plane_amount,
  input  logic [1:0]     flying_rate,
  output logic           draw_valid,
  input  logic           draw_ready,
  output logic [X_W-1:0] draw_x,
  output logic [Y_W-1:0] draw_y,
  output logic [3:0]     draw_slot,
  output logic           draw_last,
  output logic [3:0]     active_count,
  output logic           frame_done,
  output logic           tick_overrun
);

  localparam logic [4:0] SLOTS_CAP = 5'(NUM_SLOTS);
  localparam logic [3:0] LAST_IDX  = 4'(NUM_SLOTS - 1);

  state_t               state, state_nx;
  logic [NUM_SLOTS-1:0] active;
  logic [X_W-1:0]       pos_x [NUM_SLOTS];
  logic [Y_W-1:0]       pos_y [NUM_SLOTS];
  logic [3:0]           ptr;
  logic [1:0]           rate;
  logic                 pending;
  logic [6:0]           lane;

  logic                 tick_acc;
  logic                 spawn_ok;
  logic                 higher;
  logic [3:0]           free_idx;
  logic [3:0]           cur_idx;
  logic [4:0]           cap;
  logic [X_W-1:0]       step;

  lane_lfsr u_lane (
    .clk    (clk),
    .resetn (resetn),
    .enable (enable),
    .lane   (lane)
  );

  // ptr doubles as the UPDATE sweep index and the EMIT search floor.
  always_comb begin
    tick_acc = enable & tick;
    cap      = ({1'b0, plane_amount} > SLOTS_CAP) ? SLOTS_CAP : {1'b0, plane_amount};
    spawn_ok = ({1'b0, active_count} < cap);
    step     = X_W'(rate) + X_W'(1);
    free_idx = '0;
    cur_idx  = '0;
    higher   = 1'b0;
    for (int unsigned i = NUM_SLOTS; i > 0; i--) begin
      if (!active[i-1]) free_idx = 4'(i - 1);
      if (active[i-1] && (4'(i - 1) >= ptr)) cur_idx = 4'(i - 1);
    end
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (active[i] && (4'(i) > cur_idx)) higher = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (tick_acc || pending) state_nx = UPDATE;
      UPDATE:  if (ptr == LAST_IDX) state_nx = SPAWN;
      SPAWN:   state_nx = ((|active) || spawn_ok) ? EMIT : IDLE;
      EMIT:    if (draw_ready && !higher) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    draw_valid = (state == EMIT);
    draw_slot  = draw_valid ? cur_idx : '0;
    draw_x     = draw_valid ? pos_x[cur_idx] : '0;
    draw_y     = draw_valid ? pos_y[cur_idx] : '0;
    draw_last  = draw_valid & ~higher;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
      ptr          <= '0;
      rate         <= '0;
      pending      <= 1'b0;
      active_count <= '0;
      frame_done   <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      frame_done <= (state != IDLE) && (state_nx == IDLE);

      // A tick arriving while a pending one is consumed in IDLE becomes the new pending tick.
      if (state == IDLE) begin
        if (pending) pending <= tick_acc;
      end else if (tick_acc) begin
        if (pending) tick_overrun <= 1'b1;
        else         pending      <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          ptr  <= '0;
          rate <= flying_rate;
        end
        UPDATE: begin
          if (active[ptr]) begin
            if (pos_x[ptr] < step) begin
              active[ptr]  <= 1'b0;
              active_count <= active_count - 4'd1;
            end else begin
              pos_x[ptr] <= pos_x[ptr] - step;
            end
          end
          ptr <= ptr + 4'd1;
        end
        SPAWN: begin
          ptr <= '0;
          if (spawn_ok) begin
            active[free_idx] <= 1'b1;
            pos_x[free_idx]  <= X_W'(SPAWN_X);
            pos_y[free_idx]  <= Y_W'(lane);
            active_count     <= active_count + 4'd1;
          end
        end
        EMIT: begin
          if (draw_ready) ptr <= cur_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
